// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e     : command encodings carried on md_op
//   md_state_e  : sequencer states (IDLE, RUN)
//   COUNT_W     : latency countdown width (latencies up to 63)
//   helpers     : is_mul_op / is_div_op classify long-running commands
package mult_div_unit_pkg;

  localparam int COUNT_W = 6;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational result generator for the multiply/divide unit.
//   md_op  (in)  : command encoding
//   srcA   (in)  : multiplicand / dividend
//   srcB   (in)  : multiplier / divisor
//   res_hi (out) : HI result (product upper half or remainder)
//   res_lo (out) : LO result (product lower half or quotient)
// Non-arithmetic commands produce zero; the caller ignores them.
module md_compute
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   divisor_safe;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;

  // Sign-extend to full width so the truncated product is the exact signed result.
  assign prod_s = $signed({{WIDTH{srcA[WIDTH-1]}}, srcA}) *
                  $signed({{WIDTH{srcB[WIDTH-1]}}, srcB});
  assign prod_u = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};

  assign div_zero = (srcB == '0);
  assign div_ovf  = (srcA == MOST_NEG) && (srcB == '1);

  // Divide-by-zero and signed overflow are overridden below; feed the
  // dividers a harmless divisor so they never see an undefined case.
  assign divisor_safe = (div_zero || div_ovf) ? WIDTH'(1) : srcB;

  assign quo_s = $signed(srcA) / $signed(divisor_safe);
  assign rem_s = $signed(srcA) % $signed(divisor_safe);
  assign quo_u = srcA / divisor_safe;
  assign rem_u = srcA % divisor_safe;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      MD_DIV: begin
        if (div_zero) begin
          res_hi = srcA;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = MOST_NEG;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          res_hi = srcA;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   clk, reset      : clock and synchronous active-high reset
//   start, md_op    : command valid and encoding (sampled on rising edge)
//   srcA, srcB      : operands (srcA also carries MTHI/MTLO data)
//   busy            : high while a multiply/divide is in flight
//   hi_out, lo_out  : architectural HI/LO
// The result is computed at acceptance and held in pending registers; HI/LO
// only change when the latency countdown expires, modelling a pipelined unit.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [COUNT_W-1:0] MUL_CNT = COUNT_W'(MUL_LAT);
  localparam logic [COUNT_W-1:0] DIV_CNT = COUNT_W'(DIV_LAT);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  md_state_e          state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;

  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  md_compute #(
    .WIDTH (WIDTH)
  ) u_compute (
    .md_op  (md_op),
    .srcA   (srcA),
    .srcB   (srcB),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul_op(md_op) || is_div_op(md_op)) begin
            state_d   = ST_RUN;
            busy_d    = 1'b1;
            count_d   = is_mul_op(md_op) ? MUL_CNT : DIV_CNT;
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
          end else if (md_op == MD_MTHI) begin
            hi_d = srcA;
          end else if (md_op == MD_MTLO) begin
            lo_d = srcA;
          end
        end
      end
      ST_RUN: begin
        // Commands arriving here are dropped; upstream stalls on busy.
        if (count_q == CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          count_d = '0;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, randomized
// commands against an arithmetic reference model, and hand-written sequences
// for ignored commands, mid-run reset and MTHI after reset.
module tb_mult_div_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks;
  int errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(
    .WIDTH   (32),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions of each command.
  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] h, inout logic [31:0] l, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 0;
    case (op)
      3'd1: begin
        p = 64'(sa * sb);
        h = p[63:32]; l = p[31:0]; lat = MUL_LAT;
      end
      3'd2: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32]; l = p[31:0]; lat = MUL_LAT;
      end
      3'd3: begin
        lat = DIV_LAT;
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          // 64-bit arithmetic: min/-1 yields +2^31, whose low word is min, rem 0.
          q = sa / sb; r = sa % sb;
          h = 32'(r); l = 32'(q);
        end
      end
      3'd4: begin
        lat = DIV_LAT;
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          h = a % b; l = a / b;
        end
      end
      3'd5: h = a;
      3'd6: l = a;
      default: ;
    endcase
  endtask

  // Issue one command at a negedge, measure the busy window, check HI/LO
  // held during busy and the final HI/LO. Returns at the negedge after busy falls.
  task automatic do_cmd(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    int   bc;
    logic held;
    start = 1'b1; md_op = op; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    bc = 0; held = 1'b1;
    while (busy === 1'b1 && bc < 200) begin
      if (hi_out !== m_hi || lo_out !== m_lo) held = 1'b0;
      bc++;
      @(negedge clk);
    end
    check({name, ".busy_cycles"}, 64'(bc), 64'(lat));
    if (lat > 0) check({name, ".hold"}, 64'(held), 64'(1));
    check({name, ".hi"}, 64'(hi_out), 64'(eh));
    check({name, ".lo"}, 64'(lo_out), 64'(el));
    $display("cmd %s op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", name, op, a, b, bc, hi_out, lo_out);
    m_hi = eh; m_lo = el;
  endtask

  vec_t tbl[$];

  initial begin
    int   bc, lat;
    logic [2:0]  rop;
    logic [31:0] ra, rb, eh, el;

    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; srcA = '0; srcB = '0;
    m_hi = '0; m_lo = '0;

    tbl.push_back('{"mult_neg",  3'd1, 32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    tbl.push_back('{"multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{"div_m7_2",  3'd3, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tbl.push_back('{"divu_by0",  3'd4, 32'h0000_0007, 32'h0000_0000, DIV_LAT, 32'h0000_0007, 32'hFFFF_FFFF});
    tbl.push_back('{"mthi",      3'd5, 32'h0000_ABCD, 32'h0000_0000, 0,       32'h0000_ABCD, 32'hFFFF_FFFF});
    tbl.push_back('{"mtlo",      3'd6, 32'h0000_1234, 32'h0000_0000, 0,       32'h0000_ABCD, 32'h0000_1234});
    tbl.push_back('{"none",      3'd0, 32'hDEAD_BEEF, 32'h0000_0001, 0,       32'h0000_ABCD, 32'h0000_1234});
    tbl.push_back('{"unused7",   3'd7, 32'hDEAD_BEEF, 32'h0000_0001, 0,       32'h0000_ABCD, 32'h0000_1234});
    tbl.push_back('{"div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000});
    tbl.push_back('{"div_7_m2",  3'd3, 32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD});
    tbl.push_back('{"div_m5_0",  3'd3, 32'hFFFF_FFFB, 32'h0000_0000, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
    tbl.push_back('{"divu_100_7",3'd4, 32'h0000_0064, 32'h0000_0007, DIV_LAT, 32'h0000_0002, 32'h0000_000E});
    tbl.push_back('{"mult_pos",  3'd1, 32'h0001_0000, 32'h0001_0000, MUL_LAT, 32'h0000_0001, 32'h0000_0000});

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.hi", 64'(hi_out), 64'(0));
    check("reset.lo", 64'(lo_out), 64'(0));

    // Directed table; consecutive entries also exercise back-to-back issue.
    foreach (tbl[i])
      do_cmd(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].exp_hi, tbl[i].exp_lo);

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      eh = m_hi; el = m_lo;
      ref_md(rop, ra, rb, eh, el, lat);
      do_cmd($sformatf("rand%0d", i), rop, ra, rb, lat, eh, el);
    end

    // MTLO arriving on the third busy cycle must be dropped.
    start = 1'b1; md_op = 3'd3; srcA = 32'h8000_0000; srcB = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      if (bc == 3) begin
        start = 1'b1; md_op = 3'd6; srcA = 32'h0000_1234;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_mtlo.busy_cycles", 64'(bc), 64'(DIV_LAT));
    check("ign_mtlo.lo", 64'(lo_out), 64'(32'h8000_0000));
    check("ign_mtlo.hi", 64'(hi_out), 64'(0));
    @(negedge clk);
    check("ign_mtlo.idle", 64'(busy), 64'(0));
    check("ign_mtlo.lo_after", 64'(lo_out), 64'(32'h8000_0000));
    $display("cmd ign_mtlo busy=%0d hi=%h lo=%h", bc, hi_out, lo_out);
    m_hi = 32'h0; m_lo = 32'h8000_0000;

    // Reset on the fourth busy cycle of a DIVU aborts it without a commit.
    start = 1'b1; md_op = 3'd4; srcA = 32'h0000_0064; srcB = 32'h0000_0007;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 4) begin
      bc++;
      if (bc < 4) @(negedge clk);
    end
    check("abort.reached", 64'(bc), 64'(4));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.hi", 64'(hi_out), 64'(0));
    check("abort.lo", 64'(lo_out), 64'(0));
    repeat (DIV_LAT + 4) @(negedge clk);
    check("abort.hi_later", 64'(hi_out), 64'(0));
    check("abort.lo_later", 64'(lo_out), 64'(0));
    check("abort.busy_later", 64'(busy), 64'(0));
    $display("cmd abort busy=%0d hi=%h lo=%h", busy, hi_out, lo_out);
    m_hi = '0; m_lo = '0;

    do_cmd("mthi_post_reset", 3'd5, 32'h0000_ABCD, 32'h0, 0, 32'h0000_ABCD, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
